// File: rtl/fp_pkg.sv
// Shared definitions for the RV32IF floating-point decode path.
package fp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  // rd in the control bundle is sized for the architectural register count.
  localparam int RD_W     = $clog2(NREG_DEF);

  localparam logic [6:0] OP_FP    = 7'h53;
  localparam logic [6:0] OP_FLW   = 7'h07;
  localparam logic [6:0] OP_FSW   = 7'h27;
  localparam logic [6:0] OP_FMADD = 7'h43;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            mem_en;
    logic            mem_wr;
    logic            wb_en;
    logic [RD_W-1:0] rd;
  } fp_idex_ctrl_t;

endpackage

// File: rtl/fp_id_stage_if.sv
// Decode-side and ID/EX-side handshake bundle of the FP decode stage.
interface fp_id_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs1, in_rs2, in_rs3, in_rd;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic            in_mem_en, in_mem_wr, in_wb_en;

  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_rs1, out_rs2, out_rs3, out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_mem_en, out_mem_wr, out_wb_en;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data, out_rs3_data;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs3, in_rd, in_opcode, in_funct3,
           in_funct7, in_mem_en, in_mem_wr, in_wb_en, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rs3, out_rd, out_opcode,
           out_funct3, out_funct7, out_mem_en, out_mem_wr, out_wb_en,
           out_rs1_data, out_rs2_data, out_rs3_data
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs3, in_rd, in_opcode, in_funct3,
           in_funct7, in_mem_en, in_mem_wr, in_wb_en, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rs3, out_rd, out_opcode,
           out_funct3, out_funct7, out_mem_en, out_mem_wr, out_wb_en,
           out_rs1_data, out_rs2_data, out_rs3_data
  );

endinterface

// File: rtl/fp_reg_bank_mp.sv
// Multi-port FP register file: one write port, NRP combinational read ports
// with write-first bypass of the same-cycle write.
module fp_reg_bank_mp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRP  = 3,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             wr_idx_i,
  input  logic [XLEN-1:0]           wr_data_i,
  input  logic [NRP-1:0][AW-1:0]    rd_idx_i,
  output logic [NRP-1:0][XLEN-1:0]  rd_data_o
);

  logic [XLEN-1:0] mem_q [NREG];

  // NOTE: this array is flops, not RAM, and holds architectural state that
  // must read as zero after reset, so it is reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    for (int k = 0; k < NRP; k++) begin
      rd_data_o[k] = (wr_en_i && wr_idx_i == rd_idx_i[k]) ? wr_data_i
                                                          : mem_q[rd_idx_i[k]];
    end
  end

endmodule

// File: rtl/fp_id_stage.sv
// FP decode stage: register-file read with bypass into a valid/ready ID/EX
// slot whose held operands are refreshed by writeback while EX stalls.
module fp_id_stage
  import fp_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRP  = 3,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  fp_id_stage_if.slave    bus,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  logic [2:0][AW-1:0]       src_idx, cap_idx;
  logic [2:0][XLEN-1:0]     byp_data;
  logic [NRP-1:0][AW-1:0]   rd_idx;
  logic [NRP-1:0][XLEN-1:0] rd_data;

  logic                 valid_q, valid_d;
  fp_idex_ctrl_t        ctrl_q, ctrl_d;
  logic [2:0][AW-1:0]   idx_q, idx_d;
  logic [2:0][XLEN-1:0] data_q, data_d;
  logic                 capture;

  assign src_idx = {bus.in_rs3, bus.in_rs2, bus.in_rs1};

  // Ports beyond NRP capture index 0 and data 0 and are never refreshed.
  for (genvar k = 0; k < 3; k++) begin : g_port
    if (k < NRP) begin : g_live
      assign rd_idx[k]   = src_idx[k];
      assign cap_idx[k]  = src_idx[k];
      assign byp_data[k] = rd_data[k];
    end else begin : g_tied
      assign cap_idx[k]  = '0;
      assign byp_data[k] = '0;
    end
  end

  fp_reg_bank_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wb_en),
    .wr_idx_i  (wb_rd),
    .wr_data_i (wb_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !flush;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d       = 1'b1;
      ctrl_d.opcode = bus.in_opcode;
      ctrl_d.funct3 = bus.in_funct3;
      ctrl_d.funct7 = bus.in_funct7;
      ctrl_d.mem_en = bus.in_mem_en;
      ctrl_d.mem_wr = bus.in_mem_wr;
      ctrl_d.wb_en  = bus.in_wb_en;
      ctrl_d.rd     = RD_W'(bus.in_rd);
      idx_d         = cap_idx;
      data_d        = byp_data;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: pick up writebacks that land on a held source register.
      for (int k = 0; k < 3; k++) begin
        if (k < NRP && wb_en && wb_rd == idx_q[k]) data_d[k] = wb_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_rs1      = idx_q[0];
  assign bus.out_rs2      = idx_q[1];
  assign bus.out_rs3      = idx_q[2];
  assign bus.out_rd       = AW'(ctrl_q.rd);
  assign bus.out_opcode   = ctrl_q.opcode;
  assign bus.out_funct3   = ctrl_q.funct3;
  assign bus.out_funct7   = ctrl_q.funct7;
  // A bubble must never write memory or the register file downstream.
  assign bus.out_mem_en   = ctrl_q.mem_en & valid_q;
  assign bus.out_mem_wr   = ctrl_q.mem_wr & valid_q;
  assign bus.out_wb_en    = ctrl_q.wb_en  & valid_q;
  assign bus.out_rs1_data = data_q[0];
  assign bus.out_rs2_data = data_q[1];
  assign bus.out_rs3_data = data_q[2];

endmodule
